// File: rtl/reg_load_arbiter.sv
// Round-robin write arbiter in front of a register bank: capture, load for one cycle, then acknowledge.
// Build option REG_ARB_PRIO0_EN gives requester 0 fixed priority over the round-robin group 1..NREQ-1.
module reg_load_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREG-1:0]      reg_we,
  output logic [DW-1:0]        reg_d,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef REG_ARB_PRIO0_EN
  localparam logic [PW-1:0] RR_INIT = PW'(1);
`else
  localparam logic [PW-1:0] RR_INIT = '0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t          state_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   win_reg;
  logic [PW-1:0]   win_next;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   rr_next;
  logic            win_valid;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NREG-1:0] we_dec;
  logic [NREQ-1:0] gnt_dec;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
      assign gnt_dec[gi]  = (win_reg == PW'(gi));
    end
    // Addresses at or above NREG decode to no enable, so the write is silently dropped.
    for (gi = 0; gi < NREG; gi++) begin : g_we
      assign we_dec[gi] = (sel_addr == AW'(gi));
    end
  endgenerate

  assign sel_addr = addr_arr[win_next];
  assign sel_data = data_arr[win_next];

`ifdef REG_ARB_PRIO0_EN
  always_comb begin
    win_valid = 1'b0;
    win_next  = '0;
    cand      = '0;
    if (req[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int i = 0; i < NREQ - 1; i++) begin
        cand = PW'(1 + ((int'(rr_ptr_reg) - 1 + i) % (NREQ - 1)));
        if (!win_valid && req[cand]) begin
          win_valid = 1'b1;
          win_next  = cand;
        end
      end
    end
  end

  // A grant to requester 0 leaves the round-robin position untouched.
  always_comb begin
    rr_next = rr_ptr_reg;
    if (win_reg == PW'(NREQ - 1))
      rr_next = PW'(1);
    else if (win_reg != '0)
      rr_next = win_reg + PW'(1);
  end
`else
  always_comb begin
    win_valid = 1'b0;
    win_next  = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(rr_ptr_reg) + i) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_next  = cand;
      end
    end
  end

  always_comb begin
    rr_next = win_reg + PW'(1);
    if (win_reg == PW'(NREQ - 1))
      rr_next = '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= RR_INIT;
      win_reg    <= '0;
      gnt        <= '0;
      reg_we     <= '0;
      reg_d      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          gnt    <= '0;
          reg_we <= '0;
          busy   <= 1'b0;
          if (win_valid) begin
            win_reg   <= win_next;
            reg_we    <= we_dec;
            reg_d     <= sel_data;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          reg_we    <= '0;
          reg_d     <= '0;
          gnt       <= gnt_dec;
          busy      <= 1'b1;
          state_reg <= ACK;
        end
        ACK: begin
          gnt        <= '0;
          busy       <= 1'b0;
          rr_ptr_reg <= rr_next;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Randomised scoreboard bench for reg_load_arbiter; a second instance with NREG=3 exercises dropped writes.
module tb_reg_load_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int AW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   want;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt4, gnt3;
  logic [3:0]        we4;
  logic [2:0]        we3;
  logic [DW-1:0]     d4, d3;
  logic              busy4, busy3;

  assign req = want;
  always #5 clk = ~clk;

  reg_load_arbiter #(.NREQ(NREQ), .DW(DW), .NREG(4), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt4), .reg_we(we4), .reg_d(d4), .busy(busy4));

  reg_load_arbiter #(.NREQ(NREQ), .DW(DW), .NREG(3), .AW(AW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt3), .reg_we(we3), .reg_d(d3), .busy(busy3));

  typedef struct {
    int          cyc;
    int          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_gnt = 0;
  bit   hold = 1'b0;
  logic [DW-1:0] bank [4];
  logic [DW-1:0] exp_bank [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the arbiter is free three cycles after each capture; winner by round-robin scan.
  int  rr;
  int  next_free;
  bit  pend;
  int  pend_cyc;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
`ifdef REG_ARB_PRIO0_EN
  localparam int RR0 = 1;
`else
  localparam int RR0 = 0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      rr = RR0;
      next_free = 0;
      pend = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (pend && cyc == pend_cyc + 1) begin
        exp_bank[pend_addr] = pend_data;
        pend = 1'b0;
      end
      if (cyc >= next_free && req != '0) begin
        exp_t e;
        int w;
        w = -1;
`ifdef REG_ARB_PRIO0_EN
        if (req[0]) w = 0;
        for (int i = 0; i < NREQ - 1; i++) begin
          int c;
          c = 1 + ((rr - 1 + i) % (NREQ - 1));
          if (w < 0 && req[c]) w = c;
        end
        if (w != 0) rr = (w == NREQ - 1) ? 1 : w + 1;
`else
        for (int i = 0; i < NREQ; i++) begin
          int c;
          c = (rr + i) % NREQ;
          if (w < 0 && req[c]) w = c;
        end
        rr = (w + 1) % NREQ;
`endif
        e.cyc  = cyc;
        e.w    = w;
        e.addr = req_addr[w*AW +: AW];
        e.data = req_data[w*DW +: DW];
        q.push_back(e);
        next_free = cyc + 3;
        pend      = 1'b1;
        pend_cyc  = cyc;
        pend_addr = e.addr;
        pend_data = e.data;
      end
    end
  end

  // Register bank fed by the 4-register instance.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we4[i]) bank[i] = d4;
  end

  // Monitor: a LOAD cycle pops the next expectation, the following cycle must be the acknowledge.
  bit              ack_due = 1'b0;
  logic [NREQ-1:0] exp_g;
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_due = 1'b0;
      chk("rst_gnt", gnt4, 0);
      chk("rst_we", we4, 0);
      chk("rst_d", d4, 0);
      chk("rst_busy", busy4, 0);
      chk("rst_busy3", busy3, 0);
    end else if (ack_due) begin
      ack_due = 1'b0;
      chk("ack_gnt", gnt4, exp_g);
      chk("ack_gnt3", gnt3, exp_g);
      chk("ack_busy", {busy4, busy3}, 2'b11);
      chk("ack_we", {we4, we3}, 0);
    end else if (busy4 || busy3 || we4 != 0 || we3 != 0 || gnt4 != 0 || gnt3 != 0) begin
      if (q.size() == 0) begin
        chk("spurious_activity", {gnt4, we4, busy4}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("load: req %0d addr %0d data %0h at cycle %0d", e.w, e.addr, e.data, cyc);
        chk("load_latency", cyc, e.cyc);
        chk("load_we", we4, 4'b0001 << e.addr);
        chk("load_we3", we3, (e.addr < 3) ? (3'b001 << e.addr) : 3'b000);
        chk("load_d", d4, e.data);
        chk("load_d3", d3, e.data);
        chk("load_busy", {busy4, busy3}, 2'b11);
        chk("load_gnt", gnt4, 0);
        exp_g = NREQ'(1) << e.w;
        ack_due = 1'b1;
      end
    end else if (q.size() != 0 && cyc >= q[0].cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("missing_load_busy", busy4, 1);
    end
  end

  task automatic cycle();
    @(negedge clk);
    n_gnt += $countones(gnt4);
    if (!hold) want &= ~gnt4;
  endtask

  task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    want[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic drain(input int max);
    for (int n = 0; n < max; n++) begin
      if (want == '0 && q.size() == 0 && !busy4) return;
      cycle();
    end
    chk("drain_timeout", {want, busy4}, 0);
  endtask

  initial begin
    logic [DW-1:0] saved;
    for (int i = 0; i < 4; i++) begin
      bank[i] = '0;
      exp_bank[i] = '0;
    end
    rst_n = 1'b0;
    want = '0;
    req_addr = '0;
    req_data = '0;

    // Reset with random inputs, then all four requesters held with addr=i, data=i+5.
    repeat (4) begin
      @(negedge clk);
      want = NREQ'($urandom);
      req_addr = ($urandom);
      req_data = ($urandom);
    end
    for (int i = 0; i < NREQ; i++) post(i, AW'(i), DW'(i + 5));
    want = '1;
    hold = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40 && n_gnt < 5; n++) cycle();
    chk("held_grants", n_gnt >= 5, 1);
    hold = 1'b0;
    drain(30);

    // Single requester 2 writing A into register 3.
    cycle();
    post(2, 2'd3, 4'hA);
    drain(20);
    chk("bank3_after_write", bank[3], 4'hA);

    // Reset asserted early in the LOAD cycle of requester 0; the write must vanish.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    saved = bank[1];
    post(0, 2'd1, ~saved);
    post(1, 2'd2, 4'h7);
    @(posedge clk);
    #1 chk("pre_abort_we", we4, 4'b0010);
    #1 rst_n = 1'b0;
    #1 chk("abort_we_async", we4, 0);
    chk("abort_busy_async", busy4, 0);
    @(negedge clk);
    chk("abort_bank_kept", bank[1], saved);
    rst_n = 1'b1;
    drain(30);

    // Out-of-range address on the 3-register instance.
    cycle();
    post(0, 2'd3, 4'hC);
    drain(20);

`ifdef REG_ARB_PRIO0_EN
    cycle();
    post(1, 2'd1, 4'h1);
    post(2, 2'd2, 4'h2);
    post(3, 2'd3, 4'h3);
    for (int n = 0; n < 30 && !gnt4[1]; n++) cycle();
    post(0, 2'd0, 4'h9);
    drain(40);
`endif

    // Randomised traffic obeying the hold-until-grant handshake.
    repeat (400) begin
      cycle();
      for (int i = 0; i < NREQ; i++)
        if (!want[i] && $urandom_range(3) == 0) post(i, AW'($urandom), DW'($urandom));
    end
    drain(60);
    repeat (4) cycle();

    chk("queue_empty", q.size(), 0);
    for (int i = 0; i < 4; i++) chk("bank_final", bank[i], exp_bank[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
